exception_controller: RTL

//   Responder side of the exception path. Takes the exception request raised by the
//   EX-stage detector and does the following, in order:
//     - latches EPC, Cause and BadVAddr;
//     - flushes the pipeline;
//     - redirects fetch to the handler vector;
//     - on ERET, redirects fetch back to EPC.

---
 rtl/exception_controller_if.sv | 29 ++
 rtl/exception_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/exception_controller_if.sv
// Exception path bundle: detector/EX request, ERET, fetch redirect handshake and the
// CP0-visible state exported by the controller.
interface exception_controller_if;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_addr;
    logic        eret;
    logic        redirect_ready;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exl;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] badvaddr;
    logic [15:0] exc_count;

    modport master (
        output exc_req, exc_code, exc_pc, exc_addr, eret, redirect_ready,
        input  flush, stall, redirect_valid, redirect_pc, exl, epc, cause, badvaddr, exc_count
    );

    modport slave (
        input  exc_req, exc_code, exc_pc, exc_addr, eret, redirect_ready,
        output flush, stall, redirect_valid, redirect_pc, exl, epc, cause, badvaddr, exc_count
    );
endinterface

// File: rtl/exception_controller.sv
// Minimal CP0 exception responder: latches EPC/Cause/BadVAddr, flushes, vectors, returns on ERET.
// Optional macro EXC_COUNT_EN adds a saturating accepted-exception counter on exc_count.
//
//   state   | meaning
//   IDLE    | normal execution, waiting for exc_req
//   FLUSH   | killing IF/ID/EX for FLUSH_CYCLES cycles
//   VECTOR  | offering VECTOR_ADDR to fetch until accepted
//   HANDLER | handler running (exl=1), waiting for ERET
//   RETURN  | offering EPC to fetch until accepted
module exception_controller #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    exception_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FLUSH, VECTOR, HANDLER, RETURN} state_t;

    state_t     state;
    logic [3:0] flush_cnt;
    logic [4:0] cause_code;
    logic       nested;

    assign bus.cause = {nested, 24'b0, cause_code, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            flush_cnt          <= '0;
            cause_code         <= '0;
            nested             <= 1'b0;
            bus.flush          <= 1'b0;
            bus.stall          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= VECTOR_ADDR;
            bus.exl            <= 1'b0;
            bus.epc            <= '0;
            bus.badvaddr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous eret is dropped: the exception wins.
                    if (bus.exc_req) begin
                        bus.epc    <= bus.exc_pc;
                        cause_code <= bus.exc_code;
                        bus.exl    <= 1'b1;
                        if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5)
                            bus.badvaddr <= bus.exc_addr;
                        flush_cnt  <= 4'(FLUSH_CYCLES - 1);
                        bus.flush  <= 1'b1;
                        bus.stall  <= 1'b1;
                        state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        bus.flush          <= 1'b0;
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= VECTOR_ADDR;
                        state              <= VECTOR;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                VECTOR: begin
                    if (bus.redirect_ready) begin
                        bus.redirect_valid <= 1'b0;
                        bus.stall          <= 1'b0;
                        state              <= HANDLER;
                    end
                end
                HANDLER: begin
                    // Nested exceptions are only recorded, never serviced.
                    if (bus.exc_req)
                        nested <= 1'b1;
                    if (bus.eret) begin
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= bus.epc;
                        bus.stall          <= 1'b1;
                        bus.flush          <= 1'b1;
                        state              <= RETURN;
                    end
                end
                RETURN: begin
                    bus.flush <= 1'b0;
                    if (bus.redirect_ready) begin
                        bus.exl            <= 1'b0;
                        bus.redirect_valid <= 1'b0;
                        bus.stall          <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXC_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else if (state == IDLE && bus.exc_req && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
    end

    assign bus.exc_count = count_q;
`else
    assign bus.exc_count = 16'h0000;
`endif
endmodule
